// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter that shares one FIFO/LIFO write port among NREQ producers.
// Optional Full-stall timeout release is enabled by defining ARB_FULL_TIMEOUT_EN.
module fifo_wr_arbiter #(
   parameter int unsigned NREQ      = 4,
   parameter int unsigned dat_width = 32,
   parameter int unsigned BURST     = 4,
   parameter int unsigned TIMEOUT   = 16
) (
   input  logic                      Clk,
   input  logic                      Rst_n,
   input  logic [NREQ-1:0]           Req,
   input  logic [NREQ*dat_width-1:0] Req_data,
   output logic [NREQ-1:0]           Ack,
   output logic [NREQ-1:0]           Grant,
   input  logic                      Buf_full,
   output logic                      Buf_wren,
   output logic [dat_width-1:0]      Buf_datain,
   output logic                      Busy
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic IDLE = 1'b0;
   localparam logic XFER = 1'b1;

   logic                 state_q, state_d;
   logic [NREQ-1:0]      grant_q, grant_d;
   logic [PW-1:0]        gidx_q, gidx_d;
   logic [PW-1:0]        last_q, last_d;
   logic [3:0]           cnt_q, cnt_d;

   logic                 req_g;
   logic                 wren;
   logic                 timeout_hit;
   logic [dat_width-1:0] data_g;

   logic [PW:0]          start;
   logic [2*NREQ-1:0]    req_dbl;
   logic [NREQ-1:0]      req_rot;
   logic [PW:0]          offset;
   logic [PW:0]          pick_sum;
   logic [PW-1:0]        pick_idx;

   // Select the granted requester's Req bit and data word.
   always_comb begin
      req_g  = 1'b0;
      data_g = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (gidx_q == PW'(i)) begin
            req_g  = Req[i];
            data_g = Req_data[i*dat_width +: dat_width];
         end
      end
   end

   assign wren       = (state_q == XFER) & req_g & ~Buf_full;
   assign Buf_wren   = wren;
   assign Buf_datain = (state_q == XFER) ? data_g : '0;
   assign Ack        = wren ? grant_q : '0;
   assign Grant      = grant_q;
   assign Busy       = (state_q == XFER);

   // Rotate requests so the slot after the last-served one sits at bit 0, then take the lowest.
   always_comb begin
      start = {1'b0, last_q} + 1'b1;
      if (start >= (PW+1)'(NREQ)) begin
         start = '0;
      end
      req_dbl = {Req, Req} >> start;
      req_rot = req_dbl[NREQ-1:0];
      offset  = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req_rot[i]) begin
            offset = (PW+1)'(i);
         end
      end
      pick_sum = start + offset;
      if (pick_sum >= (PW+1)'(NREQ)) begin
         pick_sum = pick_sum - (PW+1)'(NREQ);
      end
      pick_idx = pick_sum[PW-1:0];
   end

`ifdef ARB_FULL_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] stall_q, stall_d;

   always_comb begin
      stall_d     = stall_q;
      timeout_hit = 1'b0;
      if (state_q == IDLE || wren) begin
         stall_d = '0;
      end else if (Buf_full && req_g) begin
         stall_d = stall_q + 1'b1;
         if (stall_d == TW'(TIMEOUT)) begin
            timeout_hit = 1'b1;
         end
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end
`else
   localparam int unsigned unused_timeout = TIMEOUT;

   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      gidx_d  = gidx_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (|Req) begin
               state_d = XFER;
               grant_d = NREQ'(1) << pick_idx;
               gidx_d  = pick_idx;
               cnt_d   = '0;
            end
         end
         XFER: begin
            if (wren) begin
               cnt_d = cnt_q + 1'b1;
            end
            if (!req_g || (wren && cnt_d == 4'(BURST)) || timeout_hit) begin
               state_d = IDLE;
               grant_d = '0;
               last_d  = gidx_q;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         gidx_q  <= '0;
         last_q  <= PW'(NREQ - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized producers,
// compared every cycle against a transaction-level model of the arbitration rules.
module tb_fifo_wr_arbiter;

   localparam int NREQ    = 4;
   localparam int DW      = 32;
   localparam int BURST   = 4;
   localparam int TIMEOUT = 16;

   logic               Clk = 1'b0;
   logic               Rst_n;
   logic [NREQ-1:0]    Req;
   logic [NREQ*DW-1:0] Req_data;
   logic [NREQ-1:0]    Ack;
   logic [NREQ-1:0]    Grant;
   logic               Buf_full;
   logic               Buf_wren;
   logic [DW-1:0]      Buf_datain;
   logic               Busy;

   fifo_wr_arbiter #(
      .NREQ      (NREQ),
      .dat_width (DW),
      .BURST     (BURST),
      .TIMEOUT   (TIMEOUT)
   ) u_dut (
      .Clk        (Clk),
      .Rst_n      (Rst_n),
      .Req        (Req),
      .Req_data   (Req_data),
      .Ack        (Ack),
      .Grant      (Grant),
      .Buf_full   (Buf_full),
      .Buf_wren   (Buf_wren),
      .Buf_datain (Buf_datain),
      .Busy       (Busy)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;

   // Model: who holds the grant, words written so far, stall length, last served.
   bit            m_busy;
   int            m_g;
   int            m_last;
   int            m_cnt;
   int            m_stall;
   int            acked;
   logic [DW-1:0] pdata [NREQ];
   logic [DW-1:0] wr_log [$];
   logic [NREQ-1:0] rs;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy  = 1'b0;
      m_g     = 0;
      m_last  = NREQ - 1;
      m_cnt   = 0;
      m_stall = 0;
   endtask

   task automatic model_release();
      m_busy = 1'b0;
      m_last = m_g;
   endtask

   // Drive one cycle of inputs, check outputs mid-cycle, then advance the model.
   task automatic cycle(input logic [NREQ-1:0] rq, input logic fl);
      logic            exp_w;
      logic [NREQ-1:0] exp_g;
      Req      = rq;
      Buf_full = fl;
      for (int i = 0; i < NREQ; i++) Req_data[i*DW +: DW] = pdata[i];
      @(negedge Clk);
      exp_g = '0;
      if (m_busy) exp_g[m_g] = 1'b1;
      exp_w = m_busy && rq[m_g] && !fl;
      check("grant", 64'(Grant), 64'(exp_g));
      check("busy", 64'(Busy), 64'(m_busy));
      check("wren", 64'(Buf_wren), 64'(exp_w));
      check("ack", 64'(Ack), exp_w ? 64'(exp_g) : 64'(0));
      if (exp_w) check("data", 64'(Buf_datain), 64'(pdata[m_g]));
      if (Buf_wren) wr_log.push_back(Buf_datain);
      acked = -1;
      if (!m_busy) begin
         for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (m_last + k) % NREQ;
            if (rq[i]) begin
               m_busy  = 1'b1;
               m_g     = i;
               m_cnt   = 0;
               m_stall = 0;
               break;
            end
         end
      end else if (!rq[m_g]) begin
         model_release();
      end else if (exp_w) begin
         acked   = m_g;
         m_cnt   = m_cnt + 1;
         m_stall = 0;
         if (m_cnt == BURST) model_release();
      end else begin
         m_stall = m_stall + 1;
`ifdef ARB_FULL_TIMEOUT_EN
         if (m_stall == TIMEOUT) model_release();
`endif
      end
      if (acked >= 0) pdata[acked] = pdata[acked] + 1;
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      Rst_n = 1'b0;
      Req   = '0;
      model_reset();
      @(posedge Clk);
      #1;
      Rst_n = 1'b1;
      wr_log.delete();
   endtask

   initial begin
      Rst_n    = 1'b0;
      Req      = '0;
      Buf_full = 1'b0;
      Req_data = '0;
      rs       = '0;
      for (int i = 0; i < NREQ; i++) pdata[i] = DW'(32'h100 * (i + 1));
      model_reset();
      #1;
      check("rst_grant", 64'(Grant), 64'(0));
      check("rst_busy", 64'(Busy), 64'(0));
      check("rst_wren", 64'(Buf_wren), 64'(0));
      check("rst_ack", 64'(Ack), 64'(0));
      check("rst_data", 64'(Buf_datain), 64'(0));
      repeat (2) @(posedge Clk);
      #1;
      Rst_n = 1'b1;

      // Single requester, six words: burst of 4, idle cycle, regrant for the last 2.
      pdata[0] = 32'hA0;
      wr_log.delete();
      repeat (8) cycle(4'b0001, 1'b0);
      repeat (2) cycle(4'b0000, 1'b0);
      check("t1_nwords", 64'(wr_log.size()), 64'(6));
      for (int k = 0; k < 6 && k < wr_log.size(); k++) check("t1_word", 64'(wr_log[k]), 64'(32'hA0 + k));

      // All requesting: rotation 0,1,2,3,0 with full bursts.
      do_reset();
      repeat (25) cycle(4'b1111, 1'b0);
      check("t2_nwords", 64'(wr_log.size()), 64'(20));

      // Requester 2 drops after 2 words; requester 3 must win next.
      do_reset();
      repeat (3) cycle(4'b0100, 1'b0);
      check("t3_nwords", 64'(wr_log.size()), 64'(2));
      repeat (3) cycle(4'b1001, 1'b0);
      check("t3_grant3", 64'(Grant), 64'(4'b1000));

      // Full for 5 cycles mid-burst; burst still totals 4.
      do_reset();
      repeat (3) cycle(4'b0001, 1'b0);
      repeat (5) cycle(4'b0001, 1'b1);
      repeat (3) cycle(4'b0001, 1'b0);
      cycle(4'b0000, 1'b0);
      check("t4_nwords", 64'(wr_log.size()), 64'(4));

      // Asynchronous reset mid-burst.
      do_reset();
      repeat (3) cycle(4'b1111, 1'b0);
      Rst_n = 1'b0;
      #1;
      check("t5_grant", 64'(Grant), 64'(0));
      check("t5_wren", 64'(Buf_wren), 64'(0));
      check("t5_busy", 64'(Busy), 64'(0));
      model_reset();
      @(posedge Clk);
      #1;
      Rst_n = 1'b1;
      repeat (6) cycle(4'b1111, 1'b0);

      // Full held with two requesters: timeout release only when enabled.
      do_reset();
      repeat (20) cycle(4'b0011, 1'b1);
`ifndef ARB_FULL_TIMEOUT_EN
      check("t6_hold", 64'(Grant), 64'(4'b0001));
`else
      check("t6_moved", 64'(Grant), 64'(4'b0010));
`endif

      // Randomized producers and back-pressure.
      do_reset();
      rs = '0;
      repeat (3000) begin
         cycle(rs, ($urandom_range(3) == 0));
         for (int i = 0; i < NREQ; i++) begin
            if (acked == i) begin
               if ($urandom_range(3) != 0) pdata[i] = $urandom;
               else rs[i] = 1'b0;
            end else if (!rs[i]) begin
               if ($urandom_range(2) == 0) begin
                  rs[i]    = 1'b1;
                  pdata[i] = $urandom;
               end
            end else if ($urandom_range(15) == 0) begin
               rs[i] = 1'b0;
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
